// File: rtl/kugelblitz_offload_ctrl_if.sv
// AXI-Lite register bus for kugelblitz_offload_ctrl.
// The master modport is the bus driver; the slave modport is the register block.
interface kugelblitz_offload_ctrl_if #(
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
);
    logic [AXIL_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
    logic [AXIL_STRB_WIDTH-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [AXIL_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;
    logic [AXIL_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/kugelblitz_offload_ctrl.sv
// kugelblitz_offload_ctrl: AXI-Lite register slave that holds per-lane offload
// requests and applies each one only at a frame boundary of that lane's stream.
// Optional build macro KUGELBLITZ_OFFLOAD_CTRL_CNT_EN adds per-lane frame
// counters and the CNT_CLR register; without it those addresses read 0 / OKAY.
//
// state    | meaning
// WR_IDLE  | waiting for awvalid & wvalid together
// WR_ACC   | awready/wready high, register written at end of this cycle
// WR_RESP  | bvalid high until bready
// RD_IDLE  | waiting for arvalid
// RD_ACC   | arready high, read data sampled at end of this cycle
// RD_RESP  | rvalid high until rready
module kugelblitz_offload_ctrl #(
    parameter int          LANE_COUNT      = 4,
    parameter int          AXIL_DATA_WIDTH = 32,
    parameter int          AXIL_ADDR_WIDTH = 8,
    parameter int          AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter logic [31:0] ID_VALUE        = 32'h4B42_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kugelblitz_offload_ctrl_if.slave s_axil,
    input  logic [LANE_COUNT-1:0] lane_tvalid,
    input  logic [LANE_COUNT-1:0] lane_tready,
    input  logic [LANE_COUNT-1:0] lane_tlast,
    output logic [LANE_COUNT-1:0] offload_en,
    output logic [LANE_COUNT-1:0] lane_in_frame
);
    // STATUS packs each lane field into a 4-bit nibble, so LANE_COUNT <= 4
    localparam int WORD_W = AXIL_ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] W_ID      = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_CTRL    = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_STATUS  = WORD_W'(2);
    localparam logic [WORD_W-1:0] W_CNT_CLR = WORD_W'(3);
    localparam logic [WORD_W-1:0] W_CNT0    = WORD_W'(4);
    localparam logic [WORD_W-1:0] W_END     = WORD_W'(4 + LANE_COUNT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_ACC, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ACC, RD_RESP} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic awready_q, awready_d;
    logic bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    logic arready_q, arready_d;
    logic rvalid_q, rvalid_d;
    logic [1:0] rresp_q, rresp_d;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LANE_COUNT-1:0] req_en_q, req_en_d;
    logic [LANE_COUNT-1:0] offload_en_q, offload_en_d;
    logic [LANE_COUNT-1:0] in_frame_q, in_frame_d;

    logic [AXIL_ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [AXIL_DATA_WIDTH-1:0] w_data;
    logic [AXIL_STRB_WIDTH-1:0] w_strb;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [AXIL_DATA_WIDTH-1:0] rd_val;
    logic [LANE_COUNT-1:0] beat, boundary;
    logic unused_bits;

    assign aw_addr = s_axil.awaddr;
    assign ar_addr = s_axil.araddr;
    assign w_data  = s_axil.wdata;
    assign w_strb  = s_axil.wstrb;
    assign wr_word = aw_addr[AXIL_ADDR_WIDTH-1:2];
    assign rd_word = ar_addr[AXIL_ADDR_WIDTH-1:2];

    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, aw_addr[1:0], ar_addr[1:0],
                           w_data[AXIL_DATA_WIDTH-1:LANE_COUNT], w_strb[AXIL_STRB_WIDTH-1:1]};

    assign beat     = lane_tvalid & lane_tready;
    assign boundary = (~in_frame_q & ~beat) | (beat & lane_tlast);

`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
    logic cnt_clr;
    logic [31:0] frame_cnt [LANE_COUNT];

    for (genvar gi = 0; gi < LANE_COUNT; gi++) begin : g_cnt
        logic [31:0] frame_cnt_q, frame_cnt_d;

        // a clear in the same cycle as a tlast beat wins over the increment
        always_comb begin
            frame_cnt_d = frame_cnt_q;
            if (cnt_clr) begin
                frame_cnt_d = '0;
            end else if (beat[gi] & lane_tlast[gi]) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
            end
        end

        // frame counter register
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                frame_cnt_q <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_d;
            end
        end

        assign frame_cnt[gi] = frame_cnt_q;
    end
`endif

    // frame tracking and boundary-aligned mode switch per lane
    always_comb begin
        in_frame_d   = in_frame_q;
        offload_en_d = offload_en_q;
        for (int i = 0; i < LANE_COUNT; i++) begin
            if (beat[i]) begin
                in_frame_d[i] = ~lane_tlast[i];
            end
            if (boundary[i]) begin
                offload_en_d[i] = req_en_q[i];
            end
        end
    end

    // write channel: accept aw+w together, write register, hold response
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        req_en_d   = req_en_q;
`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
        cnt_clr    = 1'b0;
`endif
        unique case (wr_state_q)
            WR_IDLE: begin
                if (s_axil.awvalid && s_axil.wvalid) begin
                    wr_state_d = WR_ACC;
                    awready_d  = 1'b1;
                end
            end
            WR_ACC: begin
                wr_state_d = WR_RESP;
                bvalid_d   = 1'b1;
                bresp_d    = (wr_word < W_END) ? RESP_OKAY : RESP_SLVERR;
                if (wr_word == W_CTRL && w_strb[0]) begin
                    req_en_d = w_data[LANE_COUNT-1:0];
                end
`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
                if (wr_word == W_CNT_CLR) begin
                    cnt_clr = 1'b1;
                end
`endif
            end
            WR_RESP: begin
                if (s_axil.bready) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // read data mux, evaluated in the arready cycle
    always_comb begin
        rd_val = '0;
        if (rd_word == W_ID) begin
            rd_val = ID_VALUE;
        end else if (rd_word == W_CTRL) begin
            rd_val[LANE_COUNT-1:0] = req_en_q;
        end else if (rd_word == W_STATUS) begin
            rd_val[LANE_COUNT-1:0]  = offload_en_q;
            rd_val[4 +: LANE_COUNT] = in_frame_q;
            rd_val[8 +: LANE_COUNT] = req_en_q ^ offload_en_q;
        end
`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
        for (int i = 0; i < LANE_COUNT; i++) begin
            if (rd_word == W_CNT0 + WORD_W'(i)) begin
                rd_val = frame_cnt[i];
            end
        end
`endif
    end

    // read channel: accept address, capture data, hold response
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (s_axil.arvalid) begin
                    rd_state_d = RD_ACC;
                    arready_d  = 1'b1;
                end
            end
            RD_ACC: begin
                rd_state_d = RD_RESP;
                rvalid_d   = 1'b1;
                rdata_d    = rd_val;
                rresp_d    = (rd_word < W_END) ? RESP_OKAY : RESP_SLVERR;
            end
            RD_RESP: begin
                if (s_axil.rready) begin
                    rd_state_d = RD_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // all bus, request and lane-state flops; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q   <= WR_IDLE;
            rd_state_q   <= RD_IDLE;
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            req_en_q     <= '0;
            offload_en_q <= '0;
            in_frame_q   <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            req_en_q     <= req_en_d;
            offload_en_q <= offload_en_d;
            in_frame_q   <= in_frame_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = awready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;
    assign offload_en     = offload_en_q;
    assign lane_in_frame  = in_frame_q;
endmodule

// File: tb/tb_kugelblitz_offload_ctrl.sv
// Self-checking bench for kugelblitz_offload_ctrl: table-driven lane vectors
// plus directed bus sequences. Counter expectations follow the
// KUGELBLITZ_OFFLOAD_CTRL_CNT_EN build macro.
module tb_kugelblitz_offload_ctrl;
`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
    localparam bit CNT_BUILT = 1'b1;
`else
    localparam bit CNT_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] lane_tvalid = '0;
    logic [3:0] lane_tready = 4'b1111;
    logic [3:0] lane_tlast = '0;
    logic [3:0] offload_en;
    logic [3:0] lane_in_frame;

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] en_at_update;

    kugelblitz_offload_ctrl_if axil ();

    kugelblitz_offload_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axil       (axil),
        .lane_tvalid  (lane_tvalid),
        .lane_tready  (lane_tready),
        .lane_tlast   (lane_tlast),
        .offload_en   (offload_en),
        .lane_in_frame(lane_in_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] tv;
        logic [3:0] tr;
        logic [3:0] tl;
        logic [3:0] exp_inf;
        logic [3:0] exp_en;
    } lane_vec_t;

    lane_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake did not occur within the cycle budget", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane_step(input logic [3:0] tv, input logic [3:0] tr, input logic [3:0] tl);
        lane_tvalid = tv;
        lane_tready = tr;
        lane_tlast  = tl;
        step();
        lane_tvalid = '0;
        lane_tready = 4'b1111;
        lane_tlast  = '0;
    endtask

    // upd_tv/upd_tl are driven on the lanes during the register-update cycle
    task automatic axil_write(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [3:0] upd_tv,
                              input logic [3:0] upd_tl, output logic [1:0] resp);
        bit got;
        axil.awaddr  = addr;
        axil.wdata   = data;
        axil.wstrb   = strb;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (axil.awready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            timeout_fail("aw_timeout");
            axil.awvalid = 1'b0;
            axil.wvalid  = 1'b0;
            resp = 2'b11;
            return;
        end
        lane_tvalid = upd_tv;
        lane_tlast  = upd_tl;
        step();
        lane_tvalid  = '0;
        lane_tlast   = '0;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        en_at_update = offload_en;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (axil.bvalid) begin
                got = 1;
                break;
            end
            step();
        end
        if (!got) begin
            timeout_fail("b_timeout");
            resp = 2'b11;
            return;
        end
        resp = axil.bresp;
        step();
    endtask

    task automatic axil_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        axil.rready  = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (axil.arready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            timeout_fail("ar_timeout");
            axil.arvalid = 1'b0;
            data = 32'hDEAD_BEEF;
            resp = 2'b11;
            return;
        end
        step();
        axil.arvalid = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (axil.rvalid) begin
                got = 1;
                break;
            end
            step();
        end
        if (!got) begin
            timeout_fail("r_timeout");
            data = 32'hDEAD_BEEF;
            resp = 2'b11;
            return;
        end
        data = axil.rdata;
        resp = axil.rresp;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        bit          got;

        // start: all lanes in frame, offload 0101, request 1010 (every lane pending)
        //              tv       tr       tl       exp_inf  exp_en
        vecs[0] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0101};
        vecs[1] = '{4'b0010, 4'b1111, 4'b0010, 4'b1101, 4'b0111};
        vecs[2] = '{4'b0001, 4'b1110, 4'b0001, 4'b1101, 4'b0111};
        vecs[3] = '{4'b1000, 4'b1111, 4'b0000, 4'b1101, 4'b0111};
        vecs[4] = '{4'b0101, 4'b1111, 4'b0001, 4'b1100, 4'b0110};
        vecs[5] = '{4'b0100, 4'b1011, 4'b0100, 4'b1100, 4'b0110};
        vecs[6] = '{4'b0100, 4'b1111, 4'b0100, 4'b1000, 4'b0010};
        vecs[7] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 4'b1010};
        vecs[8] = '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b1010};
        vecs[9] = '{4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b1010};

        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b1;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b1;
        en_at_update = '0;

        // reset
        rst_n = 1'b0;
        repeat (4) step();
        chk("rst_awready", axil.awready, 1'b0);
        chk("rst_wready", axil.wready, 1'b0);
        chk("rst_bvalid", axil.bvalid, 1'b0);
        chk("rst_arready", axil.arready, 1'b0);
        chk("rst_rvalid", axil.rvalid, 1'b0);
        chk("rst_rdata", axil.rdata, 32'h0);
        chk("rst_offload_en", offload_en, 4'b0000);
        chk("rst_in_frame", lane_in_frame, 4'b0000);
        rst_n = 1'b1;
        step();
        axil_read(8'h00, rd, resp);
        chk("id_value", rd, 32'h4B42_0001);
        chk("id_rresp", resp, 2'b00);
        axil_read(8'h08, rd, resp);
        chk("status_after_reset", rd, 32'h0);

        // idle enable
        axil_write(8'h04, 32'h5, 4'hF, 4'b0, 4'b0, resp);
        chk("idle_bresp", resp, 2'b00);
        chk("idle_en_at_update", en_at_update, 4'b0000);
        chk("idle_en_next_cycle", offload_en, 4'b0101);
        axil_read(8'h08, rd, resp);
        chk("idle_status", rd, 32'h0000_0005);

        // open a frame on every lane, then request 1010 and try a masked write
        lane_step(4'b1111, 4'b1111, 4'b0000);
        chk("open_in_frame", lane_in_frame, 4'b1111);
        chk("open_offload_en", offload_en, 4'b0101);
        axil_write(8'h04, 32'hFFFF_FFFA, 4'hF, 4'b0, 4'b0, resp);
        axil_write(8'h04, 32'hF, 4'b1110, 4'b0, 4'b0, resp);
        axil_read(8'h04, rd, resp);
        chk("ctrl_readback", rd, 32'h0000_000A);
        axil_read(8'h08, rd, resp);
        chk("status_pending", rd, 32'h0000_0FF5);

        // table-driven lane vectors
        for (int i = 0; i < 10; i++) begin
            lane_step(vecs[i].tv, vecs[i].tr, vecs[i].tl);
            chk($sformatf("vec%0d_in_frame", i), lane_in_frame, vecs[i].exp_inf);
            chk($sformatf("vec%0d_offload_en", i), offload_en, vecs[i].exp_en);
        end
        axil_read(8'h08, rd, resp);
        chk("status_after_table", rd, 32'h0000_000A);

        // request on lane 0 lands during beat 2 of a 4-beat frame
        axil.awaddr = 8'h04; axil.wdata = 32'h1; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
        lane_step(4'b0001, 4'b1111, 4'b0000);
        chk("mf_awready", axil.awready, 1'b1);
        chk("mf_en_beat2", offload_en[0], 1'b0);
        lane_step(4'b0001, 4'b1111, 4'b0000);
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        chk("mf_bvalid", axil.bvalid, 1'b1);
        chk("mf_en_beat3", offload_en[0], 1'b0);
        lane_step(4'b0001, 4'b1111, 4'b0000);
        chk("mf_en_beat4", offload_en[0], 1'b0);
        lane_step(4'b0001, 4'b1111, 4'b0001);
        chk("mf_en_next_first", offload_en[0], 1'b1);
        chk("mf_in_frame_next", lane_in_frame[0], 1'b0);
        lane_step(4'b0001, 4'b1111, 4'b0001);
        chk("mf_en_hold", offload_en[0], 1'b1);

        // counters on lane 2
        axil_write(8'h0C, 32'h0, 4'hF, 4'b0, 4'b0, resp);
        chk("cnt_clr_bresp", resp, 2'b00);
        repeat (3) lane_step(4'b0100, 4'b1111, 4'b0100);
        lane_step(4'b0100, 4'b1111, 4'b0000);
        lane_step(4'b0100, 4'b1111, 4'b0000);
        lane_step(4'b0100, 4'b1111, 4'b0100);
        axil_read(8'h18, rd, resp);
        chk("cnt_lane2", rd, CNT_BUILT ? 32'd4 : 32'd0);
        chk("cnt_lane2_rresp", resp, 2'b00);
        axil_read(8'h10, rd, resp);
        chk("cnt_lane0", rd, 32'd0);
        axil_read(8'h14, rd, resp);
        chk("cnt_lane1", rd, 32'd0);
        axil_read(8'h1C, rd, resp);
        chk("cnt_lane3", rd, 32'd0);
        axil_read(8'h0C, rd, resp);
        chk("cnt_clr_reads0", rd, 32'd0);
        chk("cnt_clr_rresp", resp, 2'b00);
        axil_write(8'h1C, 32'h1234, 4'hF, 4'b0, 4'b0, resp);
        chk("ro_write_bresp", resp, 2'b00);

`ifdef KUGELBLITZ_OFFLOAD_CTRL_CNT_EN
        // wrap from all-ones
        force dut.g_cnt[3].frame_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.g_cnt[3].frame_cnt_q;
        axil_read(8'h1C, rd, resp);
        chk("wrap_preload", rd, 32'hFFFF_FFFF);
        lane_step(4'b1000, 4'b1111, 4'b1000);
        axil_read(8'h1C, rd, resp);
        chk("wrap_to_zero", rd, 32'd0);
`endif

        // clear colliding with a tlast beat on lane 1
        lane_step(4'b0010, 4'b1111, 4'b0010);
        lane_step(4'b0010, 4'b1111, 4'b0010);
        axil_read(8'h14, rd, resp);
        chk("coll_precount", rd, CNT_BUILT ? 32'd2 : 32'd0);
        axil_write(8'h0C, 32'h0, 4'hF, 4'b0010, 4'b0010, resp);
        axil_read(8'h14, rd, resp);
        chk("coll_clear_wins", rd, 32'd0);

        // unmapped accesses
        axil_write(8'h40, 32'hF, 4'hF, 4'b0, 4'b0, resp);
        chk("unmapped_bresp", resp, 2'b10);
        axil_read(8'h04, rd, resp);
        chk("unmapped_no_effect", rd, 32'h1);
        axil_read(8'h40, rd, resp);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_rresp", resp, 2'b10);
        axil_write(8'h00, 32'h0, 4'hF, 4'b0, 4'b0, resp);
        chk("id_write_bresp", resp, 2'b00);

        // write response backpressure
        axil.bready = 1'b0;
        axil.awaddr = 8'h04; axil.wdata = 32'h3; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (axil.awready) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail("bp_first_aw");
        step();
        axil.wdata = 32'h7;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_bvalid_%0d", k), axil.bvalid, 1'b1);
            chk($sformatf("bp_awready_%0d", k), axil.awready, 1'b0);
            step();
        end
        chk("bp_bvalid_held", axil.bvalid, 1'b1);
        chk("bp_bresp", axil.bresp, 2'b00);
        axil.bready = 1'b1;
        step();
        chk("bp_bvalid_done", axil.bvalid, 1'b0);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (axil.awready) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail("bp_second_aw");
        step();
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (axil.bvalid) begin
                got = 1;
                break;
            end
            step();
        end
        if (!got) timeout_fail("bp_second_b");
        step();
        axil_read(8'h04, rd, resp);
        chk("bp_second_write", rd, 32'h7);

        // reset in the middle of a frame drops tracking
        lane_step(4'b0001, 4'b1111, 4'b0000);
        chk("mid_rst_in_frame_before", lane_in_frame[0], 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_in_frame", lane_in_frame, 4'b0000);
        chk("mid_rst_offload_en", offload_en, 4'b0000);
        rst_n = 1'b1;
        lane_step(4'b0001, 4'b1111, 4'b0000);
        chk("mid_rst_first_beat", lane_in_frame[0], 1'b1);
        axil_read(8'h04, rd, resp);
        chk("mid_rst_ctrl", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
